furv_mem_bridge: RTL
====================

# furv_mem_bridge

Word-to-byte memory bridge sitting directly downstream of the furv core's data-memory port. It accepts one 32-bit load or store request from the core, runs it as four little-endian byte beats on an 8-bit valid/ready external bus, and returns the assembled read word with a completion pulse. A `busy` output lets the core stall its PC while a transfer is in flight. A per-beat watchdog aborts a hung bus with an error flag.

## Interface
- `TIMEOUT`, default 255: max consecutive stalled cycles per beat before abort; 0 disables the watchdog.
- `clk` input 1: clock; the bridge uses the rising edge only. The core drives its request signals on the falling edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_en` input 1: request strobe from the core.
- `mem_read` input 1: 1 = load, 0 = store; sampled with `mem_en`.
- `addr` input 32: byte address; bits [1:0] are ignored, so accesses are word-aligned.
- `data_out` input 32: store data from the core.
- `data_in` output 32: assembled load word to the core.
- `busy` output 1: high from the acceptance edge until the return to IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; 1 = watchdog abort.
- `bus_valid` output 1: beat request.
- `bus_ready` input 1: beat accept.
- `bus_we` output 1: 1 = byte write.
- `bus_addr` output 32: byte address of the current beat.
- `bus_wdata` output 8: write byte.
- `bus_rdata` input 8: read byte, sampled when `bus_valid && bus_ready`.

## Operation
- **Reset values:** state IDLE; `busy`, `done`, `err`, `bus_valid`, `bus_we` = 0; `bus_addr`, `bus_wdata`, `data_in` = 0; beat and watchdog counters = 0.
- **States:** IDLE, XFER, DONE.
- **IDLE:**
  - If `mem_en` is high at a rising edge, latch `mem_read`, `{addr[31:2],2'b00}` and `data_out`; set beat = 0; go to XFER.
  - Otherwise stay in IDLE.
- **XFER:**
  - `bus_valid` = 1, `bus_we` = !latched read, `bus_addr` = {base[31:2], beat[1:0]}, `bus_wdata` = wdata[8·beat+7 : 8·beat].
  - A beat completes on an edge with `bus_valid && bus_ready`.
  - On a read beat completion, write `bus_rdata` into `data_in[8·beat+7 : 8·beat]`.
  - After beat 3 completes, go to DONE with `err` = 0.
- **Watchdog:**
  - Counts cycles in XFER with `bus_ready` low; clears on each completed beat.
  - When the count reaches `TIMEOUT` (and `TIMEOUT` ≠ 0), drop `bus_valid`, go to DONE with `err` = 1.
  - On abort, `data_in` holds the partial write-through: bytes already returned are updated, the rest keep their previous value.
- **DONE:** `done` = 1 for exactly one cycle, `busy` still 1; then go to IDLE.
- **Requests while not IDLE:** `mem_en` in XFER or DONE is ignored. The core holds the request until `busy` falls; it is accepted in the first IDLE cycle.
- **`data_in` retention:** holds its last value until the next read beat overwrites a lane. Stores never modify it.
- **Reset mid-transfer:** all outputs take their reset values immediately (asynchronously). No `done` pulse is issued and the partial transfer is dropped.

## Timing
- Request sampled at edge N → `busy` and `bus_valid` high after N.
- With `bus_ready` tied high: beats complete at N+1..N+4, `done` is high in the cycle after N+4, and `busy` falls after N+5. Minimum turnaround is 6 cycles per request.
- Each stalled cycle on a beat adds exactly one cycle.
- `bus_addr` and `bus_wdata` change only on a completed beat or on acceptance; they are stable while `bus_valid && !bus_ready`.
- `done` and `err` are registered outputs; there is no combinational path from any bus input to any output.

## Structure
- Shared package `furv_pkg`:
  - state enum (IDLE/XFER/DONE);
  - `BEATS` = 4;
  - `BEAT_W` = 2.
- Single module; no sub-module needed. Byte-lane select and insert are inline.

## Test plan
- Zero-wait load: `addr`=0x100, `bus_rdata` sequence 0x11,0x22,0x33,0x44 → `bus_addr` 0x100..0x103, `data_in`=0x44332211, `done` in the 5th cycle after acceptance, `err`=0.
- Store with stalls: `data_out`=0xDEADBEEF, `bus_ready` low 2 cycles per beat → `bus_wdata` EF,BE,AD,DE with `bus_we`=1; `done` 12 cycles after acceptance; `data_in` unchanged.
- Misaligned address: `addr`=0x203 → beats at 0x200..0x203.
- Timeout: `TIMEOUT`=4, `bus_ready` stuck low → `bus_valid` drops after 4 stalled cycles, `done`=1 with `err`=1.
- Back-to-back: `mem_en` held high across two requests → second accepted only in the IDLE cycle after `done`; `mem_en` during XFER/DONE is not accepted.
- Reset during beat 2 → all outputs return to reset values immediately; no `done`; a fresh request after release completes normally.

Source files
------------

// File: rtl/furv_pkg.sv
// Shared types for the furv memory bridge: FSM states and beat geometry.
package furv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;

    // Little-endian byte lane of a 32-bit word.
    function automatic logic [7:0] lane_get(input logic [31:0] word,
                                            input logic [BEAT_W-1:0] beat);
        return word[{beat, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/furv_mem_bridge.sv
// Word-to-byte bridge: one 32-bit core access becomes four little-endian byte
// beats on a valid/ready bus, with a per-beat stall watchdog.
module furv_mem_bridge
    import furv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_read;
    logic [29:0]        r_base;
    logic [31:0]        r_wdata;
    logic [BEAT_W-1:0]  r_beat;
    logic [WD_W-1:0]    r_wd;
    logic               r_err;
    logic [31:0]        r_data_in;

    logic               w_last;
    logic               w_abort;
    logic [WD_W-1:0]    w_wd_inc;
    logic               w_unused_addr;

    // Accesses are word-aligned; the low address bits are dropped on purpose.
    assign w_unused_addr = ^addr[1:0];

    assign w_wd_inc = r_wd + 1'b1;
    assign w_last   = (r_state == ST_XFER) && bus_ready && (r_beat == BEAT_W'(BEATS - 1));
    assign w_abort  = (TIMEOUT != 0) && (r_state == ST_XFER) && !bus_ready
                      && (w_wd_inc == WD_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (mem_en) w_next = ST_XFER;
            ST_XFER: if (w_last || w_abort) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read    <= 1'b0;
            r_base    <= '0;
            r_wdata   <= '0;
            r_beat    <= '0;
            r_wd      <= '0;
            r_err     <= 1'b0;
            r_data_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_en) begin
                        r_read  <= mem_read;
                        r_base  <= addr[31:2];
                        r_wdata <= data_out;
                        r_beat  <= '0;
                        r_wd    <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (bus_ready) begin
                        // Read bytes land in place so an abort leaves a partial word.
                        if (r_read) r_data_in[{r_beat, 3'b000} +: 8] <= bus_rdata;
                        r_beat <= r_beat + 1'b1;
                        r_wd   <= '0;
                    end else if (w_abort) begin
                        r_err <= 1'b1;
                        r_wd  <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_wd <= w_wd_inc;
                    end
                end
                ST_DONE: r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;
    assign data_in   = r_data_in;
    assign bus_valid = (r_state == ST_XFER);
    assign bus_we    = (r_state == ST_XFER) && !r_read;
    assign bus_addr  = {r_base, r_beat};
    assign bus_wdata = lane_get(r_wdata, r_beat);

endmodule
